rst_rename_ctrl: RTL

//  Rename/commit sequencer for the register status table (rst). Hands out ROB tags in order.

---
 rtl/rst_ctrl_pkg.sv | 15 +
 rtl/tag_ring_ptr.sv | 50 +++++
 rtl/rst_rename_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rst_ctrl_pkg.sv
// Shared constants and state encoding for the register-status-table rename/commit sequencer.
package rst_ctrl_pkg;

  localparam int TAG_W     = 5;
  localparam int ARCH_W    = 5;
  localparam int DEPTH     = 1 << TAG_W;
  localparam int FLUSH_CYC = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/tag_ring_ptr.sv
// Head/tail ROB tag pointers with an extra wrap bit; derives occupancy, full and empty.
module tag_ring_ptr #(
  parameter int TAG_W = rst_ctrl_pkg::TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] head_o,
  output logic [TAG_W-1:0] tail_o,
  output logic [TAG_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);
  import rst_ctrl_pkg::*;

  logic [TAG_W:0] head_q, head_d;
  logic [TAG_W:0] tail_q, tail_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (clear_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + (TAG_W+1)'(1);
      if (pop_i)  head_d = head_q + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // The wrap bit separates "all slots used" from "no slots used" when indices match.
  assign head_o  = head_q[TAG_W-1:0];
  assign tail_o  = tail_q[TAG_W-1:0];
  assign count_o = tail_q - head_q;
  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) && (head_q[TAG_W] != tail_q[TAG_W]);

endmodule

// File: rtl/rst_rename_ctrl.sv
// Rename/commit sequencer: issues rst tag writes on dispatch, tag clears on commit, flush on mispredict.
// Optional stall statistics enabled by defining RST_CTRL_STATS_EN.
module rst_rename_ctrl #(
  parameter int TAG_W     = rst_ctrl_pkg::TAG_W,
  parameter int ARCH_W    = rst_ctrl_pkg::ARCH_W,
  parameter int FLUSH_CYC = rst_ctrl_pkg::FLUSH_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic              disp_has_dest,
  input  logic [ARCH_W-1:0] disp_rd,
  output logic              disp_gnt,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cmt_req,
  input  logic              cmt_has_dest,
  output logic              cmt_ack,
  input  logic              mispredict,
  output logic              rst_wen,
  output logic [ARCH_W-1:0] rst_waddr,
  output logic [TAG_W-1:0]  rst_wdata,
  output logic              rst_rb_valid,
  output logic [TAG_W-1:0]  rst_rb_tag,
  output logic              rst_flush,
  output logic              full,
  output logic              empty,
  output logic [TAG_W:0]    count,
  output logic [15:0]       stall_cnt
);
  import rst_ctrl_pkg::*;

  localparam int HC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  ctrl_state_e       state_q, state_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [TAG_W-1:0]  head_tag;
  logic              run, flush_go;

  logic              wen_q, wen_d;
  logic [ARCH_W-1:0] waddr_q, waddr_d;
  logic [TAG_W-1:0]  wdata_q, wdata_d;
  logic              rbv_q, rbv_d;
  logic [TAG_W-1:0]  rbtag_q, rbtag_d;
  logic              flush_q;

  tag_ring_ptr #(.TAG_W(TAG_W)) u_ptr (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush_go),
    .push_i  (disp_gnt),
    .pop_i   (cmt_ack),
    .head_o  (head_tag),
    .tail_o  (disp_tag),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Mispredict wins over dispatch and commit in the same cycle.
  assign run      = (state_q == RUN);
  assign flush_go = run & mispredict;
  assign disp_gnt = run & ~mispredict & disp_req & ~full;
  assign cmt_ack  = run & ~mispredict & cmt_req & ~empty;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RUN:   if (mispredict) state_d = FLUSH;
      FLUSH: begin
        state_d = HOLD;
        hold_d  = '0;
      end
      HOLD: begin
        if (hold_q == HC_W'(FLUSH_CYC - 1)) state_d = RUN;
        else                               hold_d  = hold_q + HC_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wen_d   = disp_gnt & disp_has_dest;
    waddr_d = wen_d ? disp_rd  : waddr_q;
    wdata_d = wen_d ? disp_tag : wdata_q;
    rbv_d   = cmt_ack & cmt_has_dest;
    rbtag_d = rbv_d ? head_tag : rbtag_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      hold_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rbv_q   <= 1'b0;
      rbtag_q <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rbv_q   <= rbv_d;
      rbtag_q <= rbtag_d;
      flush_q <= flush_go;
    end
  end

  assign rst_wen      = wen_q;
  assign rst_waddr    = waddr_q;
  assign rst_wdata    = wdata_q;
  assign rst_rb_valid = rbv_q;
  assign rst_rb_tag   = rbtag_q;
  assign rst_flush    = flush_q;

`ifdef RST_CTRL_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (disp_req && !disp_gnt && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
